// File: rtl/la_pkg.sv
// Shared encodings for the logic-analyser capture core: FSM states, trigger
// modes and the trigger-decision helper.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } la_state_e;

  typedef enum logic [1:0] {
    TM_LEVEL = 2'b00,
    TM_RISE  = 2'b01,
    TM_FALL  = 2'b10,
    TM_NTH   = 2'b11
  } trig_mode_e;

  // hist is the match value of the previous qualified sample.
  function automatic logic trig_fire(trig_mode_e mode, logic match, logic hist,
                                     logic nth_hit);
    logic fire;
    case (mode)
      TM_LEVEL: fire = match;
      TM_RISE:  fire = match & ~hist;
      TM_FALL:  fire = ~match & hist;
      default:  fire = match & nth_hit;
    endcase
    return fire;
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Sample buffer: one write port and one registered read port, no read reset so
// it maps onto block RAM.
module la_sample_ram #(
  parameter int DATA_W = 60,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: pre-trigger fill, trigger match, post-trigger
// fill into a circular buffer, then windowed readout.
module la_capture_core
  import la_pkg::*;
#(
  parameter int DATA_W = 60,
  parameter int TRIG_W = 13,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic              capture_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [TRIG_W-1:0] trig_mask,
  input  logic [TRIG_W-1:0] trig_value,
  input  logic [1:0]        trig_mode,
  input  logic [7:0]        trig_count,
  input  logic [AW-1:0]     pre_len,
  output logic [2:0]        state_o,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_ptr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  la_state_e         state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, cnt_q, pre_len_q, trig_ptr_q, post_len, rd_phys;
  logic [7:0]        nth_q, n_req;
  logic              hist_q, triggered_q, done_q, rd_valid_q;
  logic              qual, match, nth_hit, fire, arm_ok;
  logic [DATA_W-1:0] ram_q;

  // pre_len is AW bits wide, so DEPTH-1 is already its ceiling.
  assign post_len = AW'(DEPTH - 1) - pre_len_q;
  assign qual     = capture_en && (state_q inside {ST_PREFILL, ST_WAIT_TRIG, ST_POST});
  assign match    = ((trig_i ^ trig_value) & trig_mask) == '0;
  assign n_req    = (trig_count == 8'd0) ? 8'd1 : trig_count;
  assign nth_hit  = ({1'b0, nth_q} + 9'd1) >= {1'b0, n_req};
  assign fire     = qual && (state_q == ST_WAIT_TRIG) &&
                    trig_fire(trig_mode_e'(trig_mode), match, hist_q, nth_hit);
  assign arm_ok   = arm && !abort && (state_q inside {ST_IDLE, ST_DONE});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE:
        if (arm_ok) state_d = (pre_len == '0) ? ST_WAIT_TRIG : ST_PREFILL;
      ST_PREFILL:
        if (qual && cnt_q == pre_len_q - 1'b1) state_d = ST_WAIT_TRIG;
      ST_WAIT_TRIG:
        if (fire) state_d = (post_len == '0) ? ST_DONE : ST_POST;
      ST_POST:
        if (qual && cnt_q == post_len - 1'b1) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pre_len_q   <= '0;
      trig_ptr_q  <= '0;
      nth_q       <= '0;
      hist_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_en && (state_q == ST_DONE);
      if (abort) begin
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
      end else if (arm_ok) begin
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        pre_len_q   <= pre_len;
        trig_ptr_q  <= '0;
        nth_q       <= '0;
        hist_q      <= 1'b0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        if (qual) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          hist_q   <= match;
        end
        // cnt counts qualified samples within the current fill phase only.
        if (state_d != state_q) cnt_q <= '0;
        else if (qual && (state_q inside {ST_PREFILL, ST_POST})) cnt_q <= cnt_q + 1'b1;
        if (qual && state_q == ST_WAIT_TRIG && trig_mode_e'(trig_mode) == TM_NTH &&
            match && !fire)
          nth_q <= nth_q + 8'd1;
        if (fire) begin
          trig_ptr_q  <= wr_ptr_q;
          triggered_q <= 1'b1;
        end
        if (state_d == ST_DONE && state_q != ST_DONE) done_q <= 1'b1;
      end
    end
  end

  // Readout: rd_en is a request with no backpressure; rd_valid qualifies
  // rd_data exactly one cycle later, and only while in DONE.
  assign rd_phys = trig_ptr_q - pre_len_q + rd_addr;

  la_sample_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk   (sys_clk),
    .we    (qual),
    .waddr (wr_ptr_q),
    .wdata (data_i),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

  assign rd_data   = rd_valid_q ? ram_q : '0;
  assign rd_valid  = rd_valid_q;
  assign state_o   = state_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_ptr  = trig_ptr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at DEPTH=16: trigger modes, pre_len
// boundaries, abort, reset mid-capture and qualified-only storage.
module tb_la_capture_core;

  localparam int DATA_W = 60;
  localparam int TRIG_W = 13;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT = 3'd2,
                         S_POST = 3'd3, S_DONE = 3'd4;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic [TRIG_W-1:0] trig_i = '0;
  logic              capture_en = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [TRIG_W-1:0] trig_mask = '0;
  logic [TRIG_W-1:0] trig_value = '0;
  logic [1:0]        trig_mode = 2'b00;
  logic [7:0]        trig_count = '0;
  logic [AW-1:0]     pre_len = '0;
  logic [2:0]        state_o;
  logic              triggered, done, rd_valid;
  logic [AW-1:0]     trig_ptr;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  la_capture_core #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_i(data_i), .trig_i(trig_i),
    .capture_en(capture_en), .arm(arm), .abort(abort), .trig_mask(trig_mask),
    .trig_value(trig_value), .trig_mode(trig_mode), .trig_count(trig_count),
    .pre_len(pre_len), .state_o(state_o), .triggered(triggered), .done(done),
    .trig_ptr(trig_ptr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  // Clock and watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change 1ns after the rising edge, outputs are read there too.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int idx, input logic [TRIG_W-1:0] t, input logic en);
    data_i     = DATA_W'(idx);
    trig_i     = t;
    capture_en = en;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int exp_data);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(rd_data), 64'(exp_data));
  endtask

  task automatic config_trig(input int pl, input logic [1:0] mode, input int mask,
                             input int value, input int cnt);
    pre_len    = AW'(pl);
    trig_mode  = mode;
    trig_mask  = TRIG_W'(mask);
    trig_value = TRIG_W'(value);
    trig_count = 8'(cnt);
  endtask

  // Directed sequence
  initial begin
    repeat (3) tick();
    chk("rst_state", 64'(state_o), 64'(S_IDLE));
    chk("rst_trig", 64'(triggered), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ptr", 64'(trig_ptr), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    sys_rst = 1'b0;
    tick();

    // Level trigger at 20, window 16..31
    config_trig(4, 2'b00, 'hFFF, 20, 0);
    do_arm();
    chk("lvl_prefill", 64'(state_o), 64'(S_PRE));
    for (int i = 0; i <= 3; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("lvl_wait", 64'(state_o), 64'(S_WAIT));
    for (int i = 4; i <= 20; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("lvl_post", 64'(state_o), 64'(S_POST));
    chk("lvl_trig", 64'(triggered), 64'd1);
    chk("lvl_ptr", 64'(trig_ptr), 64'd4);
    for (int i = 21; i <= 30; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("lvl_notdone", 64'(done), 64'd0);
    feed(31, TRIG_W'(31), 1'b1);
    chk("lvl_done", 64'(done), 64'd1);
    chk("lvl_st_done", 64'(state_o), 64'(S_DONE));
    for (int r = 0; r < DEPTH; r++) rd_chk("lvl_rd", r, 16 + r);
    tick();
    chk("lvl_rdv_idle", 64'(rd_valid), 64'd0);

    // Rising edge: trig_i matches on 10..14 and again at 17
    config_trig(4, 2'b01, 'hFFF, 10, 0);
    do_arm();
    for (int i = 0; i <= 21; i++) begin
      feed(i, ((i >= 10 && i <= 14) || i == 17) ? TRIG_W'(10) : TRIG_W'(i), 1'b1);
      if (i == 9)  chk("rise_pre9", 64'(triggered), 64'd0);
      if (i == 10) chk("rise_ptr10", 64'(trig_ptr), 64'd10);
      if (i == 20) chk("rise_notdone", 64'(done), 64'd0);
    end
    chk("rise_done", 64'(done), 64'd1);
    chk("rise_ptr", 64'(trig_ptr), 64'd10);
    rd_chk("rise_rd4", 4, 10);
    rd_chk("rise_rd0", 0, 6);
    rd_chk("rise_rd15", 15, 21);

    // Nth match: third match at 13
    config_trig(4, 2'b11, 'h1FFF, 'h100, 3);
    do_arm();
    for (int i = 0; i <= 24; i++) begin
      feed(i, (i == 5 || i == 9 || i == 13) ? TRIG_W'('h100) : TRIG_W'(i), 1'b1);
      if (i == 9)  chk("nth_wait9", 64'(state_o), 64'(S_WAIT));
      if (i == 13) chk("nth_post13", 64'(state_o), 64'(S_POST));
    end
    chk("nth_done", 64'(done), 64'd1);
    chk("nth_ptr", 64'(trig_ptr), 64'd13);
    rd_chk("nth_rd4", 4, 13);

    // pre_len = 0 with mask 0: first sample triggers
    config_trig(0, 2'b00, 0, 'h55, 0);
    do_arm();
    chk("pl0_wait", 64'(state_o), 64'(S_WAIT));
    feed(100, 13'd0, 1'b1);
    chk("pl0_post", 64'(state_o), 64'(S_POST));
    chk("pl0_trig", 64'(triggered), 64'd1);
    for (int i = 1; i <= 15; i++) feed(100 + i, 13'd0, 1'b1);
    chk("pl0_done", 64'(done), 64'd1);
    chk("pl0_ptr", 64'(trig_ptr), 64'd0);
    rd_chk("pl0_rd0", 0, 100);
    rd_chk("pl0_rd15", 15, 115);

    // Abort during POST, abort beats arm, then re-arm
    config_trig(4, 2'b00, 'hFFF, 8, 0);
    do_arm();
    for (int i = 0; i <= 10; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("abt_post", 64'(state_o), 64'(S_POST));
    abort = 1'b1;
    feed(11, TRIG_W'(11), 1'b1);
    abort = 1'b0;
    chk("abt_idle", 64'(state_o), 64'(S_IDLE));
    chk("abt_done", 64'(done), 64'd0);
    chk("abt_trig", 64'(triggered), 64'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("abt_rdv", 64'(rd_valid), 64'd0);
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    chk("abt_wins", 64'(state_o), 64'(S_IDLE));
    config_trig(4, 2'b00, 'hFFF, 20, 0);
    do_arm();
    for (int i = 0; i <= 31; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("rearm_done", 64'(done), 64'd1);
    chk("rearm_ptr", 64'(trig_ptr), 64'd4);
    rd_chk("rearm_rd0", 0, 16);
    rd_chk("rearm_rd4", 4, 20);

    // capture_en on even indices only
    config_trig(4, 2'b00, 'hFFF, 20, 0);
    do_arm();
    for (int i = 0; i <= 42; i++) begin
      feed(i, TRIG_W'(i), (i % 2) == 0);
      if (i == 41) chk("tog_notdone", 64'(done), 64'd0);
    end
    chk("tog_done", 64'(done), 64'd1);
    chk("tog_ptr", 64'(trig_ptr), 64'd10);
    rd_chk("tog_rd0", 0, 12);
    rd_chk("tog_rd4", 4, 20);
    rd_chk("tog_rd15", 15, 42);

    // Reset while waiting for a trigger that never comes
    config_trig(4, 2'b00, 'h1FFF, 'h1FFF, 0);
    do_arm();
    for (int i = 0; i <= 7; i++) feed(i, TRIG_W'(i), 1'b1);
    chk("rst2_wait", 64'(state_o), 64'(S_WAIT));
    sys_rst = 1'b1;
    rd_en   = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst2_state", 64'(state_o), 64'(S_IDLE));
    chk("rst2_trig", 64'(triggered), 64'd0);
    chk("rst2_done", 64'(done), 64'd0);
    chk("rst2_ptr", 64'(trig_ptr), 64'd0);
    chk("rst2_rdv", 64'(rd_valid), 64'd0);
    chk("rst2_rdd", 64'(rd_data), 64'd0);
    tick();
    rd_en = 1'b0;
    chk("rst2_rdv_idle", 64'(rd_valid), 64'd0);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
LA_CAPTURE_CORE -- requirements
Module: la_capture_core

Interface
REQ-001 SHALL have parameter DATA_W, default 60, meaning captured sample width.
REQ-002 SHALL have parameter TRIG_W, default 13, meaning trigger input width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning buffer samples (power of two); AW = log2(DEPTH).
REQ-004 SHALL have port sys_clk  in  1  meaning the only clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst  in  1  meaning synchronous, active-high reset.
REQ-006 SHALL have ports data_i in DATA_W (sample), trig_i in TRIG_W (trigger source), capture_en in 1 (sample qualifier).
REQ-007 SHALL have ports arm in 1 (start pulse) and abort in 1 (cancel pulse).
REQ-008 SHALL have config ports trig_mask in TRIG_W, trig_value in TRIG_W, trig_mode in 2, trig_count in 8, pre_len in AW.
REQ-009 SHALL have status ports state_o out 3, triggered out 1, done out 1, trig_ptr out AW.
REQ-010 SHALL have readout ports rd_en in 1, rd_addr in AW, rd_data out DATA_W, rd_valid out 1.

Function
REQ-011 SHALL implement states IDLE, PREFILL, WAIT_TRIG, POST, DONE, encoded on state_o.
REQ-012 SHALL, on arm in IDLE or DONE, clear pointers and counters, set triggered=0 and done=0, and enter PREFILL; arm SHALL be ignored in other states.
REQ-013 SHALL, on abort in any state, enter IDLE next cycle with done=0 and triggered=0; abort SHALL win over a simultaneous arm.
REQ-014 SHALL write data_i to the buffer at wr_ptr and advance wr_ptr modulo DEPTH only on cycles where capture_en=1 in PREFILL, WAIT_TRIG or POST.
REQ-015 SHALL leave PREFILL for WAIT_TRIG after pre_len qualified samples; pre_len=0 SHALL skip PREFILL (arm goes directly to WAIT_TRIG).
REQ-016 SHALL compute match = (((trig_i XOR trig_value) AND trig_mask) == 0); mask 0 SHALL always match.
REQ-017 SHALL evaluate triggers only in WAIT_TRIG on qualified cycles; trig_mode 00 = level match, 01 = match rising, 10 = match falling, 11 = Nth qualified match with N = trig_count (0 treated as 1).
REQ-018 SHALL update the edge-history register on every qualified cycle in all capture states, clearing it on arm.
REQ-019 SHALL, on trigger, store the trigger sample, latch trig_ptr = its address, set triggered=1, and enter POST.
REQ-020 SHALL store exactly DEPTH-1-pre_len further qualified samples in POST, then enter DONE with done=1.
REQ-021 SHALL define window start = (trig_ptr - pre_len) mod DEPTH; rd_data SHALL equal buffer[(start + rd_addr) mod DEPTH].
REQ-022 SHALL return rd_data with rd_valid=1 exactly one cycle after rd_en, only in DONE; rd_en in other states SHALL produce rd_valid=0.
REQ-023 SHALL require pre_len < DEPTH; a larger value SHALL be clamped to DEPTH-1.

Reset
REQ-024 SHALL, on sys_rst, enter IDLE; state_o=IDLE, triggered=0, done=0, trig_ptr=0, rd_valid=0, rd_data=0, pointers, counters and edge history=0.
REQ-025 SHALL apply reset mid-capture identically; buffer contents need not be cleared.

Structure
REQ-026 SHALL take the state enum and trig_mode encodings from shared package la_pkg.
REQ-027 SHALL instantiate one sub-module la_sample_ram (one write port, one registered read port, BRAM-inferable).

Verification (DEPTH=16, pre_len=4, capture_en=1, data_i = trig_i = sample index)
REQ-028 SHALL check: level mode, mask 0xFFF, value 20, arm at index 0 -> trigger at 20, done after index 31; rd_addr 0..15 -> 16..31; rd_addr 4 -> 20.
REQ-029 SHALL check: rising mode, trig_i held matching for indices 10..14 -> single trigger at 10, no retrigger.
REQ-030 SHALL check: Nth mode, trig_count=3, matches at 5, 9 and 13 -> trigger at 13, trig_ptr=13 mod 16.
REQ-031 SHALL check: pre_len=0, mask=0 -> trigger on the first WAIT_TRIG cycle; rd_addr 0 -> first sample after arm.
REQ-032 SHALL check: abort during POST -> IDLE next cycle, done=0, rd_en gives rd_valid=0; re-arm captures correctly.
REQ-033 SHALL check: sys_rst during WAIT_TRIG and capture_en toggling 1/0 -> reset values per REQ-024; unqualified cycles store nothing.
